// File: rtl/countdown_sched.sv
// rtl/countdown_sched.sv - two-requester round-robin sequencer for a shared W-bit down-counter
module countdown_sched #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [1:0]   req,
    input  logic [W-1:0] ld0,
    input  logic [W-1:0] ld1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic         busy,
    output logic [W-1:0] o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [W-1:0] CNT_ZERO = '0;
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [1:0]   state_q, state_d;
    logic [W-1:0] cnt_q,   cnt_d;
    logic [1:0]   gnt_q,   gnt_d;
    logic [1:0]   done_q,  done_d;
    logic         busy_q,  busy_d;
    logic         last_q,  last_d;
    logic         own_q,   own_d;

    logic         pick_valid;
    logic         pick_idx;
    logic [W-1:0] pick_ld;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Round-robin pick: a lone request wins outright, a tie goes to the requester not served last
    always_comb begin
        pick_valid = |req;
        pick_idx   = 1'b0;
        case (req)
            2'b01:   pick_idx = 1'b0;
            2'b10:   pick_idx = 1'b1;
            2'b11:   pick_idx = ~last_q;
            default: pick_idx = 1'b0;
        endcase
        pick_ld = pick_idx ? ld1 : ld0;
    end

    // Sequencer next-state: grant and load, count with abort priority, single-cycle completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = 2'b00;
        busy_d  = busy_q;
        last_d  = last_q;
        own_d   = own_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d = S_COUNT;
                    own_d   = pick_idx;
                    last_d  = pick_idx;
                    gnt_d   = onehot(pick_idx);
                    cnt_d   = pick_ld;
                    busy_d  = 1'b1;
                end else begin
                    gnt_d  = 2'b00;
                    busy_d = 1'b0;
                end
            end
            S_COUNT: begin
                if (!req[own_q]) begin
                    // Owner withdrew: drop silently, no completion pulse
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                    cnt_d   = CNT_ZERO;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d = S_DONE;
                    gnt_d   = 2'b00;
                    done_d  = onehot(own_q);
                    busy_d  = 1'b1;
                end else if (en) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                cnt_d   = CNT_ZERO;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything and favours requester 0 on the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            busy_q  <= 1'b0;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            own_q   <= own_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = busy_q;
    assign o    = cnt_q;

endmodule
